bht_ram_scheduler: RTL and testbench
====================================

Name: bht_ram_scheduler

Overview:
- Sequences the single-port counter SRAM of one branch-predictor bank (one row = INSTR_PER_FETCH counters).
- Shares the port between front-end lookups and queued resolved-branch updates.
- Performs each update as a read-modify-write of a saturating counter.
- Sweeps the array to weakly-not-taken after reset and on flush.

Parameters:
- NR_ROWS, 64, rows in the SRAM.
- INSTR_PER_FETCH, 2, counters per row.
- CTR_BITS, 2, bits per counter.
- FIFO_DEPTH, 4, update queue entries.
- STARVE_LIMIT, 8, consecutive deferred cycles before an update overrides lookups.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- flush_i  in  1  restart array sweep.
- debug_mode_i  in  1  drop updates while high.
- lookup_req_i  in  1  front-end read request.
- lookup_row_i  in  $clog2(NR_ROWS)  lookup row.
- lookup_gnt_o  out  1  lookup issued to RAM this cycle.
- upd_valid_i  in  1  update valid.
- upd_row_i  in  $clog2(NR_ROWS)  update row.
- upd_col_i  in  $clog2(INSTR_PER_FETCH)  counter within row.
- upd_taken_i  in  1  resolved direction.
- upd_ready_o  out  1  update accepted when valid&ready.
- ram_req_o  out  1  RAM access.
- ram_we_o  out  1  write.
- ram_addr_o  out  $clog2(NR_ROWS)  row address.
- ram_wdata_o  out  INSTR_PER_FETCH*CTR_BITS  write row.
- ram_rdata_i  in  INSTR_PER_FETCH*CTR_BITS  read row, valid the cycle after a read request.
- busy_o  out  1  reset-wait or sweep in progress.

Behaviour:
- Clocking: one clock. Reset is asynchronous and active-high on rst_i.
- States: RST_WAIT, FLUSH, IDLE, UPD_READ, UPD_WRITE.
- Reset: state=RST_WAIT, sweep pointer=0, FIFO empty, starve counter=0.
  - Outputs while in reset and in RST_WAIT: ram_req_o=0, ram_we_o=0, ram_addr_o=0, ram_wdata_o=0, lookup_gnt_o=0, upd_ready_o=0, busy_o=1.
  - RST_WAIT -> FLUSH unconditionally.
- FLUSH:
  - Each cycle: ram_req_o=1, ram_we_o=1, ram_addr_o=ptr, ram_wdata_o = every counter 'b01 (weakly-not-taken, zero-extended to CTR_BITS).
  - ptr increments each cycle; after writing row NR_ROWS-1 -> IDLE. Duration is exactly NR_ROWS cycles.
  - busy_o=1, lookup_gnt_o=0, upd_ready_o=0.
- flush_i=1 in any state: next state FLUSH, ptr=0, FIFO cleared, starve counter=0, in-flight RMW abandoned (its write is never issued).
  - In FLUSH, flush_i restarts ptr at 0.
  - flush_i has priority over every other event in that cycle.
- Update FIFO:
  - upd_ready_o = !full && state in {IDLE, UPD_READ, UPD_WRITE}.
  - Push on upd_valid_i&&upd_ready_o&&!debug_mode_i. With debug_mode_i=1, the handshake completes but the update is discarded.
  - No bypass: ready=0 when full, even if a pop occurs that cycle.
  - Pop when the UPD_WRITE write issues.
- IDLE arbitration:
  - Lookup wins if lookup_req_i=1 and (FIFO empty or starve<STARVE_LIMIT): lookup_gnt_o=1, ram_req_o=1, we=0, addr=lookup_row_i. Starve increments (saturating) if the FIFO is non-empty.
  - Otherwise, if FIFO non-empty: read head row (req=1, we=0, addr=head.row), lookup_gnt_o=0, starve=0 -> UPD_READ.
  - Otherwise no RAM access.
- UPD_READ:
  - Register ram_rdata_i.
  - Port is free: a lookup (if requested) is granted as in IDLE, without the starve test.
  - -> UPD_WRITE.
- UPD_WRITE:
  - Write the captured row with counter [head.col] replaced: taken -> +1 saturating at 2^CTR_BITS-1; not-taken -> -1 saturating at 0. Other counters are unchanged.
  - lookup_gnt_o=0, pop FIFO -> IDLE.
- Ordering and hazards:
  - Only one RMW is in flight, so same-row updates serialise in order.
  - A lookup in UPD_READ of the row being updated returns the pre-update value; this is allowed.
- Latency: update pushed at cycle 0 with no lookups -> read at cycle 1, capture at cycle 2, write at cycle 3.

Test Plan:
- Reset release: rst_i high 2 cycles then low -> 1 cycle RST_WAIT, then 64 consecutive writes to rows 0..63 with wdata 'b0101, busy_o=1 throughout, then busy_o=0 and upd_ready_o=1.
- Single update after sweep: row 5, col 1, taken, rdata 'b0101 -> read addr 5 at cycle+1, write addr 5 wdata 'b1001 at cycle+3; 3 more taken -> 'b1101 then stays 'b1101; 4 not-taken on col 0 -> col 0 saturates at 'b00.
- Lookup priority and starvation: lookup_req_i held high, 1 queued update -> lookup_gnt_o=1 for 8 IDLE cycles, then 1 cycle gnt=0 with update read, gnt=1 in UPD_READ, gnt=0 in UPD_WRITE.
- FIFO full: 5 back-to-back updates with lookup held high -> upd_ready_o=0 on the 5th attempt; ready returns the cycle after the first pop.
- Flush mid-RMW: flush_i asserted in UPD_READ -> no UPD_WRITE write, FIFO empty, 64-row sweep from row 0; flush_i again at ptr=20 -> sweep restarts at row 0.
- Debug mode: debug_mode_i=1, 3 valid updates -> all handshake, zero RAM writes; asynchronous reset mid-sweep at ptr=30 -> outputs zero immediately, full sweep from row 0 after release.

Source files
------------

// File: rtl/bht_ram_scheduler_if.sv
// Port bundle between the BHT bank scheduler, the front-end/update sources and the counter SRAM.
// The scheduler connects through the slave modport; the master modport is the opposite side.
interface bht_ram_scheduler_if #(
  parameter int NR_ROWS         = 64,
  parameter int INSTR_PER_FETCH = 2,
  parameter int CTR_BITS        = 2
);
  localparam int ROW_W  = $clog2(NR_ROWS);
  localparam int COL_W  = (INSTR_PER_FETCH > 1) ? $clog2(INSTR_PER_FETCH) : 1;
  localparam int DATA_W = INSTR_PER_FETCH * CTR_BITS;

  logic              lookup_req_i;
  logic [ROW_W-1:0]  lookup_row_i;
  logic              lookup_gnt_o;
  logic              upd_valid_i;
  logic [ROW_W-1:0]  upd_row_i;
  logic [COL_W-1:0]  upd_col_i;
  logic              upd_taken_i;
  logic              upd_ready_o;
  logic              ram_req_o;
  logic              ram_we_o;
  logic [ROW_W-1:0]  ram_addr_o;
  logic [DATA_W-1:0] ram_wdata_o;
  logic [DATA_W-1:0] ram_rdata_i;

  modport slave (
    input  lookup_req_i, lookup_row_i, upd_valid_i, upd_row_i, upd_col_i, upd_taken_i, ram_rdata_i,
    output lookup_gnt_o, upd_ready_o, ram_req_o, ram_we_o, ram_addr_o, ram_wdata_o
  );

  modport master (
    output lookup_req_i, lookup_row_i, upd_valid_i, upd_row_i, upd_col_i, upd_taken_i, ram_rdata_i,
    input  lookup_gnt_o, upd_ready_o, ram_req_o, ram_we_o, ram_addr_o, ram_wdata_o
  );
endinterface

// File: rtl/bht_ram_scheduler.sv
// Single-port counter SRAM sequencer for one branch-predictor bank: lookups, queued
// read-modify-write counter updates, and a weakly-not-taken sweep after reset/flush.
module bht_ram_scheduler #(
  parameter int NR_ROWS         = 64,
  parameter int INSTR_PER_FETCH = 2,
  parameter int CTR_BITS        = 2,
  parameter int FIFO_DEPTH      = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic flush_i,
  input  logic debug_mode_i,
  output logic busy_o,
  bht_ram_scheduler_if.slave bus
);
  localparam int ROW_W  = $clog2(NR_ROWS);
  localparam int COL_W  = (INSTR_PER_FETCH > 1) ? $clog2(INSTR_PER_FETCH) : 1;
  localparam int DATA_W = INSTR_PER_FETCH * CTR_BITS;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int STV_W  = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [2:0] {RST_WAIT, FLUSH, IDLE, UPD_READ, UPD_WRITE} state_t;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             taken;
  } upd_entry_t;

  state_t            r_state, w_state_next;
  logic [ROW_W-1:0]  r_ptr, w_ptr_next;
  logic [STV_W-1:0]  r_starve, w_starve_next;
  upd_entry_t        r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_rdata;

  upd_entry_t        w_head;
  logic              w_empty, w_full, w_ready, w_push, w_pop, w_capture;
  logic              w_req, w_we, w_gnt;
  logic [ROW_W-1:0]  w_addr;
  logic [DATA_W-1:0] w_wdata, w_sweep_row, w_mod_row;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_head  = r_fifo[r_rd_ptr];
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_ready = !w_full && (r_state == IDLE || r_state == UPD_READ || r_state == UPD_WRITE);
  assign w_push  = bus.upd_valid_i && w_ready && !debug_mode_i && !flush_i;

  // Per-counter saturating update of the captured row, plus the sweep pattern.
  for (genvar gi = 0; gi < INSTR_PER_FETCH; gi++) begin : g_ctr
    logic [CTR_BITS-1:0] w_old, w_new_ctr;
    logic                w_sel;
    assign w_old = r_rdata[gi*CTR_BITS +: CTR_BITS];
    assign w_sel = (w_head.col == COL_W'(gi));
    always_comb begin
      w_new_ctr = w_old;
      if (w_head.taken && w_old != '1)
        w_new_ctr = w_old + 1'b1;
      else if (!w_head.taken && w_old != '0)
        w_new_ctr = w_old - 1'b1;
    end
    assign w_mod_row[gi*CTR_BITS +: CTR_BITS]   = w_sel ? w_new_ctr : w_old;
    assign w_sweep_row[gi*CTR_BITS +: CTR_BITS] = CTR_BITS'(1);
  end

  always_comb begin
    w_state_next  = r_state;
    w_ptr_next    = r_ptr;
    w_starve_next = r_starve;
    w_req         = 1'b0;
    w_we          = 1'b0;
    w_addr        = '0;
    w_wdata       = '0;
    w_gnt         = 1'b0;
    w_pop         = 1'b0;
    w_capture     = 1'b0;
    // A flush cycle issues nothing, so an abandoned RMW never reaches the array.
    if (flush_i) begin
      w_state_next  = FLUSH;
      w_ptr_next    = '0;
      w_starve_next = '0;
    end else begin
      case (r_state)
        RST_WAIT: w_state_next = FLUSH;
        FLUSH: begin
          w_req      = 1'b1;
          w_we       = 1'b1;
          w_addr     = r_ptr;
          w_wdata    = w_sweep_row;
          w_ptr_next = r_ptr + 1'b1;
          if (r_ptr == ROW_W'(NR_ROWS - 1)) begin
            w_state_next = IDLE;
            w_ptr_next   = '0;
          end
        end
        IDLE: begin
          if (bus.lookup_req_i && (w_empty || r_starve < STV_W'(STARVE_LIMIT))) begin
            w_gnt  = 1'b1;
            w_req  = 1'b1;
            w_addr = bus.lookup_row_i;
            if (!w_empty)
              w_starve_next = r_starve + 1'b1;
          end else if (!w_empty) begin
            w_req         = 1'b1;
            w_addr        = w_head.row;
            w_starve_next = '0;
            w_state_next  = UPD_READ;
          end
        end
        UPD_READ: begin
          w_capture = 1'b1;
          if (bus.lookup_req_i) begin
            w_gnt  = 1'b1;
            w_req  = 1'b1;
            w_addr = bus.lookup_row_i;
          end
          w_state_next = UPD_WRITE;
        end
        UPD_WRITE: begin
          w_req        = 1'b1;
          w_we         = 1'b1;
          w_addr       = w_head.row;
          w_wdata      = w_mod_row;
          w_pop        = 1'b1;
          w_state_next = IDLE;
        end
        default: w_state_next = RST_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= RST_WAIT;
      r_ptr    <= '0;
      r_starve <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rdata  <= '0;
    end else begin
      r_state  <= w_state_next;
      r_ptr    <= w_ptr_next;
      r_starve <= w_starve_next;
      if (w_capture)
        r_rdata <= bus.ram_rdata_i;
      if (flush_i) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push)
          r_wr_ptr <= ptr_inc(r_wr_ptr);
        if (w_pop)
          r_rd_ptr <= ptr_inc(r_rd_ptr);
        if (w_push && !w_pop)
          r_count <= r_count + 1'b1;
        else if (w_pop && !w_push)
          r_count <= r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push)
      r_fifo[r_wr_ptr] <= '{row: bus.upd_row_i, col: bus.upd_col_i, taken: bus.upd_taken_i};
  end

  assign bus.ram_req_o    = w_req;
  assign bus.ram_we_o     = w_we;
  assign bus.ram_addr_o   = w_addr;
  assign bus.ram_wdata_o  = w_wdata;
  assign bus.lookup_gnt_o = w_gnt;
  assign bus.upd_ready_o  = w_ready;
  assign busy_o           = (r_state == RST_WAIT) || (r_state == FLUSH);
endmodule

// File: tb/tb_bht_ram_scheduler.sv
// Self-checking bench for bht_ram_scheduler: a per-cycle scoreboard of queued updates and
// golden counter rows, plus directed cycle-exact checks with hand-computed values.
module tb_bht_ram_scheduler;
  logic clk = 1'b0;
  logic rst_i, flush_i, debug_mode_i, busy_o;
  always #5 clk = ~clk;

  bht_ram_scheduler_if #(.NR_ROWS(64), .INSTR_PER_FETCH(2), .CTR_BITS(2)) bus ();

  bht_ram_scheduler #(
    .NR_ROWS(64), .INSTR_PER_FETCH(2), .CTR_BITS(2), .FIFO_DEPTH(4), .STARVE_LIMIT(8)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .debug_mode_i(debug_mode_i),
    .busy_o(busy_o), .bus(bus)
  );

  // Behavioural single-port SRAM: read data returned the cycle after the request.
  logic [3:0] mem [64];
  always @(posedge clk) begin
    if (bus.ram_req_o && bus.ram_we_o) mem[bus.ram_addr_o] <= bus.ram_wdata_o;
    if (bus.ram_req_o && !bus.ram_we_o) bus.ram_rdata_i <= mem[bus.ram_addr_o];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct { int row; int col; bit taken; } upd_t;
  upd_t       upd_q[$];
  logic [3:0] ref_mem [64];
  int         busy_cnt = 65;
  int         upd_writes = 0;
  bit         exp_ready;

  function automatic logic [3:0] apply_upd(input logic [3:0] rv, input int col, input bit taken);
    int c;
    c = int'((rv >> (2 * col)) & 4'h3);
    if (taken) c = (c < 3) ? c + 1 : 3;
    else       c = (c > 0) ? c - 1 : 0;
    return (rv & ~(4'h3 << (2 * col))) | (4'(c) << (2 * col));
  endfunction

  task automatic reset_model();
    upd_q.delete();
    for (int i = 0; i < 64; i++) ref_mem[i] = 4'b0101;
  endtask

  always @(negedge clk) begin
    if (rst_i) begin
      chk("rst_outputs", {bus.ram_req_o, bus.ram_we_o, bus.ram_addr_o, bus.ram_wdata_o,
                          bus.lookup_gnt_o, bus.upd_ready_o}, 0);
      chk("rst_busy", busy_o, 1);
      busy_cnt = 65;
      reset_model();
    end else if (flush_i) begin
      chk("flush_cycle_req", bus.ram_req_o, 0);
      chk("flush_cycle_gnt", bus.lookup_gnt_o, 0);
      busy_cnt = 64;
      reset_model();
    end else if (busy_cnt == 65) begin
      chk("rstwait_outputs", {bus.ram_req_o, bus.ram_we_o, bus.ram_addr_o, bus.ram_wdata_o,
                              bus.lookup_gnt_o, bus.upd_ready_o}, 0);
      chk("rstwait_busy", busy_o, 1);
      busy_cnt = 64;
    end else if (busy_cnt > 0) begin
      chk("sweep_write", {bus.ram_req_o, bus.ram_we_o, bus.ram_addr_o, bus.ram_wdata_o},
          {1'b1, 1'b1, 6'(64 - busy_cnt), 4'b0101});
      chk("sweep_busy_gnt_rdy", {busy_o, bus.lookup_gnt_o, bus.upd_ready_o}, 3'b100);
      busy_cnt--;
    end else begin
      chk("idle_busy", busy_o, 0);
      exp_ready = (upd_q.size() < 4);
      chk("upd_ready", bus.upd_ready_o, exp_ready);
      if (bus.lookup_gnt_o) begin
        chk("gnt_access", {bus.lookup_req_i, bus.ram_req_o, bus.ram_we_o, bus.ram_addr_o},
            {1'b1, 1'b1, 1'b0, bus.lookup_row_i});
      end else if (bus.ram_req_o && !bus.ram_we_o) begin
        chk("upd_read_queued", upd_q.size() > 0, 1);
        if (upd_q.size() > 0) chk("upd_read_row", bus.ram_addr_o, upd_q[0].row);
      end else if (bus.ram_req_o && bus.ram_we_o) begin
        upd_writes++;
        chk("upd_write_queued", upd_q.size() > 0, 1);
        if (upd_q.size() > 0) begin
          upd_t u;
          logic [3:0] w;
          u = upd_q.pop_front();
          w = apply_upd(ref_mem[u.row], u.col, u.taken);
          chk("upd_write_addr", bus.ram_addr_o, u.row);
          chk("upd_write_data", bus.ram_wdata_o, w);
          ref_mem[u.row] = w;
          $display("txn update write row=%0d col=%0d taken=%0d wdata=%b", u.row, u.col, u.taken, w);
        end
      end
      if (bus.upd_valid_i && exp_ready && !debug_mode_i)
        upd_q.push_back('{row: int'(bus.upd_row_i), col: int'(bus.upd_col_i), taken: bus.upd_taken_i});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic check_reset_sweep();
    smp();
    chk("rstwait_req", bus.ram_req_o, 0);
    chk("rstwait_busy_d", busy_o, 1);
    for (int i = 0; i < 64; i++) begin
      step(); smp();
      chk("sweep_row", {bus.ram_we_o, bus.ram_addr_o, bus.ram_wdata_o}, {1'b1, 6'(i), 4'b0101});
    end
    step(); smp();
    chk("post_sweep_busy_ready", {busy_o, bus.upd_ready_o}, 2'b01);
    $display("txn sweep complete");
  endtask

  task automatic do_update(input int row, input int col, input bit taken, input logic [3:0] exp_w);
    step();
    bus.upd_valid_i = 1; bus.upd_row_i = 6'(row); bus.upd_col_i = 1'(col); bus.upd_taken_i = taken;
    smp(); chk("single_push_ready", bus.upd_ready_o, 1);
    step(); bus.upd_valid_i = 0;
    smp(); chk("single_read", {bus.ram_req_o, bus.ram_we_o, bus.ram_addr_o}, {1'b1, 1'b0, 6'(row)});
    step(); smp(); chk("single_capture_idle", bus.ram_req_o, 0);
    step(); smp();
    chk("single_write", {bus.ram_req_o, bus.ram_we_o, bus.ram_addr_o, bus.ram_wdata_o},
        {1'b1, 1'b1, 6'(row), exp_w});
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (upd_q.size() != 0 && n < 200) begin step(); n++; end
    chk(name, upd_q.size(), 0);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_i = 1; flush_i = 0; debug_mode_i = 0;
    bus.lookup_req_i = 0; bus.lookup_row_i = 0;
    bus.upd_valid_i = 0; bus.upd_row_i = 0; bus.upd_col_i = 0; bus.upd_taken_i = 0;

    // Reset release and initial sweep
    @(posedge clk); @(posedge clk); #1; rst_i = 0;
    check_reset_sweep();

    // Single updates: col 1 counts up and saturates, then col 0 counts down to 0
    do_update(5, 1, 1, 4'b1001);
    do_update(5, 1, 1, 4'b1101);
    do_update(5, 1, 1, 4'b1101);
    do_update(5, 1, 1, 4'b1101);
    for (int i = 0; i < 4; i++) do_update(5, 0, 0, 4'b1100);

    // Lookup priority and starvation override
    step();
    bus.lookup_req_i = 1; bus.lookup_row_i = 7;
    bus.upd_valid_i = 1; bus.upd_row_i = 9; bus.upd_col_i = 0; bus.upd_taken_i = 1;
    smp(); chk("starve_c0_gnt", bus.lookup_gnt_o, 1);
    step(); bus.upd_valid_i = 0;
    for (int c = 1; c <= 8; c++) begin
      smp(); chk("starve_lookup_gnt", {bus.lookup_gnt_o, bus.ram_addr_o}, {1'b1, 6'd7});
      step();
    end
    smp(); chk("starve_override_read", {bus.lookup_gnt_o, bus.ram_req_o, bus.ram_addr_o}, {1'b0, 1'b1, 6'd9});
    step(); smp(); chk("starve_updread_gnt", bus.lookup_gnt_o, 1);
    step(); smp();
    chk("starve_write", {bus.lookup_gnt_o, bus.ram_we_o, bus.ram_addr_o, bus.ram_wdata_o},
        {1'b0, 1'b1, 6'd9, 4'b0110});
    step(); smp(); chk("starve_after_gnt", bus.lookup_gnt_o, 1);

    // FIFO full with lookups held
    for (int c = 0; c < 4; c++) begin
      step();
      bus.upd_valid_i = 1; bus.upd_row_i = 6'(10 + c); bus.upd_col_i = 0; bus.upd_taken_i = 1;
      smp(); chk("full_push_ready", bus.upd_ready_o, 1);
    end
    step(); bus.upd_row_i = 14;
    for (int c = 4; c <= 11; c++) begin
      smp(); chk("full_not_ready", bus.upd_ready_o, 0);
      if (c == 11)
        chk("full_first_pop", {bus.ram_we_o, bus.ram_addr_o, bus.ram_wdata_o}, {1'b1, 6'd10, 4'b0110});
      step();
    end
    smp(); chk("full_ready_returns", bus.upd_ready_o, 1);
    step(); bus.upd_valid_i = 0; bus.lookup_req_i = 0;
    wait_drain("full_drain");
    $display("txn fifo-full test done");

    // Flush mid-RMW, then flush again at sweep row 20
    step();
    bus.upd_valid_i = 1; bus.upd_row_i = 20; bus.upd_col_i = 0; bus.upd_taken_i = 1;
    smp(); chk("flush_push_ready", bus.upd_ready_o, 1);
    step(); bus.upd_valid_i = 0;
    smp(); chk("flush_rmw_read", {bus.ram_req_o, bus.ram_we_o, bus.ram_addr_o}, {1'b1, 1'b0, 6'd20});
    step(); flush_i = 1;
    smp(); chk("flush_in_updread_req", bus.ram_req_o, 0);
    step(); flush_i = 0;
    smp(); chk("flush_sweep_row0", {busy_o, bus.ram_we_o, bus.ram_addr_o, bus.ram_wdata_o}, {1'b1, 1'b1, 6'd0, 4'b0101});
    for (int i = 1; i < 20; i++) begin step(); smp(); end
    chk("flush_at_row19", bus.ram_addr_o, 19);
    step(); flush_i = 1;
    smp(); chk("reflush_req", bus.ram_req_o, 0);
    step(); flush_i = 0;
    smp(); chk("reflush_row0", {bus.ram_we_o, bus.ram_addr_o}, {1'b1, 6'd0});
    for (int i = 1; i < 64; i++) begin step(); smp(); end
    chk("reflush_last_row", bus.ram_addr_o, 63);
    step(); smp(); chk("reflush_done", {busy_o, bus.upd_ready_o}, 2'b01);
    $display("txn flush test done");

    // Debug mode drops updates
    base = upd_writes;
    step(); debug_mode_i = 1;
    for (int c = 0; c < 3; c++) begin
      bus.upd_valid_i = 1; bus.upd_row_i = 6'(30 + c); bus.upd_col_i = 1; bus.upd_taken_i = 1;
      smp(); chk("debug_handshake", bus.upd_ready_o, 1);
      step();
    end
    bus.upd_valid_i = 0;
    for (int c = 0; c < 10; c++) step();
    chk("debug_no_writes", upd_writes - base, 0);
    debug_mode_i = 0;
    $display("txn debug test done");

    // Asynchronous reset mid-sweep at row 30
    step(); flush_i = 1;
    step(); flush_i = 0;
    for (int i = 1; i <= 30; i++) step();
    smp(); chk("areset_at_row30", bus.ram_addr_o, 30);
    @(posedge clk); #3; rst_i = 1; #1;
    chk("areset_immediate", {bus.ram_req_o, bus.ram_we_o, bus.ram_addr_o, bus.ram_wdata_o,
                             bus.lookup_gnt_o, bus.upd_ready_o, busy_o}, 1);
    @(posedge clk); @(posedge clk); #1; rst_i = 0;
    check_reset_sweep();

    // One last update after the re-sweep confirms counters restarted at weakly-not-taken
    do_update(5, 1, 0, 4'b0001);
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
